// File: rtl/block_reducer_pkg.sv
// block_reducer_pkg
//   Shared types and constants for the block reducer: the controller state
//   encoding, the address-width derivation and the reset fill values for
//   the running minimum and maximum.
package block_reducer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        COLLECT = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Bits needed to index DEPTH words; DEPTH is a power of two.
    function automatic int addrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Fill bits for the min/max registers on reset and on clear: the
    // minimum starts at all-ones and the maximum at zero so the first beat
    // always replaces both.
    localparam logic MIN_INIT_BIT = 1'b1;
    localparam logic MAX_INIT_BIT = 1'b0;

endpackage

// File: rtl/block_reducer_acc.sv
// block_reducer_acc
//   Sum / minimum / maximum / count datapath for one block of beats.
//   Ports:
//     clk, rst   clock and asynchronous active-high reset
//     clear      restart the reduction (sum=0, min=all-ones, max=0, count=0)
//     beat       accumulate data this cycle
//     data       unsigned beat value
//     sum        zero-extended running sum; wide enough for DEPTH full beats
//     minVal     running unsigned minimum
//     maxVal     running unsigned maximum
//     count      beats accumulated so far (0..DEPTH)
module block_reducer_acc
    import block_reducer_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    beat,
    input  logic [WIDTH-1:0]        data,
    output logic [WIDTH+ADDR_W-1:0] sum,
    output logic [WIDTH-1:0]        minVal,
    output logic [WIDTH-1:0]        maxVal,
    output logic [ADDR_W:0]         count
);

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum    <= '0;
            minVal <= {WIDTH{MIN_INIT_BIT}};
            maxVal <= {WIDTH{MAX_INIT_BIT}};
            count  <= '0;
        end else if (clear) begin
            sum    <= '0;
            minVal <= {WIDTH{MIN_INIT_BIT}};
            maxVal <= {WIDTH{MAX_INIT_BIT}};
            count  <= '0;
        end else if (beat) begin
            sum    <= sum + {{ADDR_W{1'b0}}, data};
            minVal <= (data < minVal) ? data : minVal;
            maxVal <= (data > maxVal) ? data : maxVal;
            count  <= count + 1'b1;
        end
    end

endmodule

// File: rtl/block_reducer.sv
// block_reducer
//   Requests one block from the multiplier with a single EN_blockRead pulse,
//   reduces the DEPTH returned beats to sum/min/max/count and presents the
//   result behind a valid/ready handshake. A watchdog closes a stalled burst
//   after TIMEOUT idle cycles and flags it.
//   Ports:
//     clk, rst        clock and asynchronous active-high reset
//     start           request a reduction (sampled only in IDLE)
//     busy            registered: controller is not IDLE
//     RDY_mult        multiplier ready; gates EN_blockRead
//     EN_blockRead    registered one-cycle read request
//     VALID_memVal    beat strobe, memVal_data its unsigned payload
//     result_valid    result fields valid and held
//     result_ready    consumer takes the result
//     result_sum/min/max/count/timeout   reduction result
//     stray_beat      sticky: a beat arrived outside collection
module block_reducer
    import block_reducer_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int DEPTH   = 64,
    parameter  int TIMEOUT = 16,
    localparam int ADDR_W  = addrWidth(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    input  logic                    RDY_mult,
    output logic                    EN_blockRead,
    input  logic                    VALID_memVal,
    input  logic [WIDTH-1:0]        memVal_data,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [WIDTH+ADDR_W-1:0] result_sum,
    output logic [WIDTH-1:0]        result_min,
    output logic [WIDTH-1:0]        result_max,
    output logic [ADDR_W:0]         result_count,
    output logic                    result_timeout,
    output logic                    stray_beat
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    state_t            state;
    state_t            stateNext;
    logic              enNext;
    logic              timeoutSet;
    logic [IDLE_W-1:0] idleCount;

    // The cycle carrying EN_blockRead belongs to the request, not the burst:
    // a beat there is a stray and it does not count toward the watchdog.
    logic collecting;
    logic beatAccept;
    logic strayEvent;
    logic startAccept;
    logic lastBeat;
    logic idleCycle;
    logic watchdogFire;

    assign collecting   = (state == COLLECT) && !EN_blockRead;
    assign beatAccept   = collecting && VALID_memVal;
    assign strayEvent   = VALID_memVal && !beatAccept;
    assign startAccept  = (state == IDLE) && start;
    assign lastBeat     = beatAccept && (result_count == (ADDR_W+1)'(DEPTH - 1));
    assign idleCycle    = collecting && !VALID_memVal;
    assign watchdogFire = idleCycle && (idleCount == IDLE_W'(TIMEOUT - 1));

    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        stateNext  = state;
        enNext     = 1'b0;
        timeoutSet = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) stateNext = REQ;
            end
            REQ: begin
                if (RDY_mult) begin
                    enNext    = 1'b1;
                    stateNext = COLLECT;
                end
            end
            COLLECT: begin
                if (lastBeat) begin
                    stateNext = DONE;
                end else if (watchdogFire) begin
                    stateNext  = DONE;
                    timeoutSet = 1'b1;
                end
            end
            DONE: begin
                // start is deliberately ignored here.
                if (result_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            busy           <= 1'b0;
            EN_blockRead   <= 1'b0;
            result_valid   <= 1'b0;
            result_timeout <= 1'b0;
            stray_beat     <= 1'b0;
            idleCount      <= '0;
        end else begin
            state        <= stateNext;
            // Decoding the next state keeps busy/result_valid glitch-free
            // and aligned with the state register.
            busy         <= (stateNext != IDLE);
            result_valid <= (stateNext == DONE);
            EN_blockRead <= enNext;

            if (startAccept)     result_timeout <= 1'b0;
            else if (timeoutSet) result_timeout <= 1'b1;

            // A stray coinciding with the clearing start is still recorded.
            stray_beat <= (stray_beat && !startAccept) || strayEvent;

            if (idleCycle) idleCount <= idleCount + 1'b1;
            else           idleCount <= '0;
        end
    end

    block_reducer_acc #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clear  (startAccept),
        .beat   (beatAccept),
        .data   (memVal_data),
        .sum    (result_sum),
        .minVal (result_min),
        .maxVal (result_max),
        .count  (result_count)
    );

endmodule

// File: tb/tb_block_reducer.sv
// tb_block_reducer
//   Directed bench for block_reducer: full bursts, saturated data, watchdog
//   timeout, delayed multiplier ready, result hold under backpressure and
//   asynchronous reset mid-burst.
module tb_block_reducer;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 64;
    localparam int TIMEOUT = 16;
    localparam int ADDR_W  = 6;

    logic                    clk;
    logic                    rst;
    logic                    start;
    logic                    busy;
    logic                    RDY_mult;
    logic                    EN_blockRead;
    logic                    VALID_memVal;
    logic [WIDTH-1:0]        memVal_data;
    logic                    result_valid;
    logic                    result_ready;
    logic [WIDTH+ADDR_W-1:0] result_sum;
    logic [WIDTH-1:0]        result_min;
    logic [WIDTH-1:0]        result_max;
    logic [ADDR_W:0]         result_count;
    logic                    result_timeout;
    logic                    stray_beat;

    block_reducer #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .RDY_mult       (RDY_mult),
        .EN_blockRead   (EN_blockRead),
        .VALID_memVal   (VALID_memVal),
        .memVal_data    (memVal_data),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result_sum     (result_sum),
        .result_min     (result_min),
        .result_max     (result_max),
        .result_count   (result_count),
        .result_timeout (result_timeout),
        .stray_beat     (stray_beat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkResult(input string tag, input logic [63:0] sum, input logic [63:0] mn,
                               input logic [63:0] mx, input logic [63:0] cnt, input logic [63:0] to);
        check({tag, ".valid"},   result_valid,   1);
        check({tag, ".sum"},     result_sum,     sum);
        check({tag, ".min"},     result_min,     mn);
        check({tag, ".max"},     result_max,     mx);
        check({tag, ".count"},   result_count,   cnt);
        check({tag, ".timeout"}, result_timeout, to);
    endtask

    task automatic checkResetState(input string tag);
        check({tag, ".busy"},    busy,           0);
        check({tag, ".en"},      EN_blockRead,   0);
        check({tag, ".valid"},   result_valid,   0);
        check({tag, ".sum"},     result_sum,     0);
        check({tag, ".min"},     result_min,     64'hFFFF_FFFF);
        check({tag, ".max"},     result_max,     0);
        check({tag, ".count"},   result_count,   0);
        check({tag, ".timeout"}, result_timeout, 0);
        check({tag, ".stray"},   stray_beat,     0);
    endtask

    // Start, let the EN_blockRead cycle pass with no beat (RDY_mult high).
    task automatic launch;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
    endtask

    task automatic accept(input string tag);
        result_ready = 1'b1;
        tick;
        result_ready = 1'b0;
        check({tag, ".idle_busy"},  busy,         0);
        check({tag, ".idle_valid"}, result_valid, 0);
    endtask

    int earlyDone;
    int enPulses;
    int busyLow;
    int changed;
    logic [WIDTH+ADDR_W-1:0] heldSum;

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        RDY_mult     = 1'b0;
        VALID_memVal = 1'b0;
        memVal_data  = '0;
        result_ready = 1'b0;
        #2;
        checkResetState("reset");
        tick;
        tick;
        rst = 1'b0;
        tick;

        // Burst 1: squares 0..63.
        RDY_mult = 1'b1;
        start    = 1'b1;
        tick;
        start = 1'b0;
        check("b1.busy_req", busy, 1);
        check("b1.en_req",   EN_blockRead, 0);
        tick;
        check("b1.en_pulse", EN_blockRead, 1);
        tick;
        check("b1.en_drop",  EN_blockRead, 0);
        for (int i = 0; i < DEPTH; i++) begin
            VALID_memVal = 1'b1;
            memVal_data  = WIDTH'(i * i);
            if (i == DEPTH - 1) check("b1.valid_early", result_valid, 0);
            tick;
        end
        VALID_memVal = 1'b0;
        checkResult("b1", 85344, 0, 3969, 64, 0);
        check("b1.stray", stray_beat, 0);
        accept("b1");

        // Burst 2: all-ones data, full-width sum.
        launch;
        for (int i = 0; i < DEPTH; i++) begin
            VALID_memVal = 1'b1;
            memVal_data  = '1;
            tick;
        end
        VALID_memVal = 1'b0;
        checkResult("b2", 64'd274877906880, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64, 0);
        accept("b2");

        // Burst 3: stray in the EN cycle, 10 beats of 5, then watchdog.
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        check("b3.en_pulse", EN_blockRead, 1);
        VALID_memVal = 1'b1;
        memVal_data  = 100;
        tick;
        check("b3.stray_en", stray_beat, 1);
        check("b3.stray_cnt", result_count, 0);
        for (int i = 0; i < 10; i++) begin
            VALID_memVal = 1'b1;
            memVal_data  = 5;
            tick;
        end
        VALID_memVal = 1'b0;
        earlyDone = 0;
        repeat (TIMEOUT - 1) begin
            tick;
            if (result_valid) earlyDone++;
        end
        check("b3.early_done", earlyDone, 0);
        tick;
        checkResult("b3", 50, 5, 5, 10, 1);
        check("b3.busy", busy, 1);
        accept("b3");

        // Burst 4: RDY_mult low for 7 cycles, then zero-beat timeout.
        RDY_mult = 1'b0;
        start    = 1'b1;
        tick;
        start    = 1'b0;
        enPulses = 0;
        busyLow  = 0;
        repeat (6) begin
            tick;
            if (EN_blockRead) enPulses++;
            if (!busy) busyLow++;
        end
        RDY_mult = 1'b1;
        tick;
        check("b4.en_pulses_before", enPulses, 0);
        check("b4.busy_low", busyLow, 0);
        check("b4.en_pulse", EN_blockRead, 1);
        tick;
        check("b4.en_once", EN_blockRead, 0);
        earlyDone = 0;
        repeat (TIMEOUT - 1) begin
            tick;
            if (result_valid) earlyDone++;
        end
        check("b4.early_done", earlyDone, 0);
        tick;
        checkResult("b4", 0, 64'hFFFF_FFFF, 0, 0, 1);

        // Backpressure: result held, start ignored in DONE.
        heldSum = result_sum;
        changed = 0;
        start   = 1'b1;
        repeat (5) begin
            tick;
            if (!result_valid || result_sum !== heldSum || result_count !== '0 ||
                result_timeout !== 1'b1 || EN_blockRead) changed++;
        end
        check("hold.changed", changed, 0);
        result_ready = 1'b1;
        tick;
        start        = 1'b0;
        result_ready = 1'b0;
        check("hold.accept_busy", busy, 0);
        tick;
        check("hold.no_restart", busy, 0);
        check("hold.no_en", EN_blockRead, 0);

        // Burst 5: reset after 30 beats while beats keep coming.
        launch;
        for (int i = 0; i < 30; i++) begin
            VALID_memVal = 1'b1;
            memVal_data  = 7;
            tick;
        end
        check("b5.count30", result_count, 30);
        #3;
        rst = 1'b1;
        #1;
        checkResetState("async_rst");
        #2;
        rst = 1'b0;
        tick;
        tick;
        tick;
        check("b5.post_stray", stray_beat, 1);
        check("b5.post_count", result_count, 0);
        check("b5.post_sum",   result_sum, 0);
        check("b5.post_busy",  busy, 0);
        VALID_memVal = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
